// File: rtl/conv_stream_tx.sv
// Streams one 14x14 IFM frame plus a 3x3 kernel from two synchronous memories into
// the convolution engine's in_valid / In_IFM / In_Weight input burst.
module conv_stream_tx #(
    parameter int DATA_W  = 16,
    parameter int IMG_DIM = 14,
    parameter int K_NUM   = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              ifm_rd_en,
    output logic [7:0]        ifm_addr,
    input  logic [DATA_W-1:0] ifm_rdata,
    output logic              w_rd_en,
    output logic [3:0]        w_addr,
    input  logic [DATA_W-1:0] w_rdata,
    output logic              in_valid,
    output logic [DATA_W-1:0] In_IFM,
    output logic [DATA_W-1:0] In_Weight,
    output logic              busy,
    output logic              done,
    output logic [7:0]        frame_cnt,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_e;

    localparam logic [7:0] LAST_ADDR = 8'(IMG_DIM * IMG_DIM - 1);
    localparam logic [3:0] LAST_W    = 4'(K_NUM - 1);

    state_e            state_q, state_d;
    logic              ifm_rd_en_q, ifm_rd_en_d;
    logic [7:0]        ifm_addr_q, ifm_addr_d;
    logic              w_rd_en_q, w_rd_en_d;
    logic [3:0]        w_addr_q, w_addr_d;
    logic              stage1_q, stage1_d;
    logic              w_stage1_q, w_stage1_d;
    logic              in_valid_q, in_valid_d;
    logic [DATA_W-1:0] in_ifm_q, in_ifm_d;
    logic [DATA_W-1:0] in_weight_q, in_weight_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ifm_rd_en_q <= 1'b0;
            ifm_addr_q  <= '0;
            w_rd_en_q   <= 1'b0;
            w_addr_q    <= '0;
            stage1_q    <= 1'b0;
            w_stage1_q  <= 1'b0;
            in_valid_q  <= 1'b0;
            in_ifm_q    <= '0;
            in_weight_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ifm_rd_en_q <= ifm_rd_en_d;
            ifm_addr_q  <= ifm_addr_d;
            w_rd_en_q   <= w_rd_en_d;
            w_addr_q    <= w_addr_d;
            stage1_q    <= stage1_d;
            w_stage1_q  <= w_stage1_d;
            in_valid_q  <= in_valid_d;
            in_ifm_q    <= in_ifm_d;
            in_weight_q <= in_weight_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ifm_rd_en_d = ifm_rd_en_q;
        ifm_addr_d  = ifm_addr_q;
        w_rd_en_d   = w_rd_en_q;
        w_addr_d    = w_addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;

        // Read enables travel one stage alongside the memory latency; data is forced
        // to zero outside the burst because the engine shifts on every cycle.
        stage1_d    = ifm_rd_en_q;
        w_stage1_d  = w_rd_en_q;
        in_valid_d  = stage1_q;
        in_ifm_d    = stage1_q ? ifm_rdata : '0;
        in_weight_d = w_stage1_q ? w_rdata : '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = READ;
                    ifm_rd_en_d = 1'b1;
                    ifm_addr_d  = '0;
                    w_rd_en_d   = 1'b1;
                    w_addr_d    = '0;
                    busy_d      = 1'b1;
                end
            end
            READ: begin
                ifm_addr_d = ifm_addr_q + 8'd1;
                if (w_addr_q < LAST_W) begin
                    w_addr_d  = w_addr_q + 4'd1;
                    w_rd_en_d = 1'b1;
                end else begin
                    w_rd_en_d = 1'b0;
                end
                if (ifm_addr_q == LAST_ADDR) begin
                    ifm_rd_en_d = 1'b0;
                    ifm_addr_d  = '0;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                // Stage 1 empty means in_valid falls on this edge: the last beat is out.
                if (!stage1_q) begin
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ifm_rd_en = ifm_rd_en_q;
    assign ifm_addr  = ifm_addr_q;
    assign w_rd_en   = w_rd_en_q;
    assign w_addr    = w_addr_q;
    assign in_valid  = in_valid_q;
    assign In_IFM    = in_ifm_q;
    assign In_Weight = in_weight_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_conv_stream_tx.sv
// Bench for conv_stream_tx: behavioural frame-schedule model, per-cycle compare,
// directed scenarios with hand-computed pins, and randomized start stimulus.
module tb_conv_stream_tx;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          ifm_rd_en;
    logic [7:0]    ifm_addr;
    logic [DW-1:0] ifm_rdata = '1;
    logic          w_rd_en;
    logic [3:0]    w_addr;
    logic [DW-1:0] w_rdata = '1;
    logic          in_valid;
    logic [DW-1:0] In_IFM;
    logic [DW-1:0] In_Weight;
    logic          busy;
    logic          done;
    logic [7:0]    frame_cnt;
    logic [1:0]    dbg_state;

    conv_stream_tx #(.DATA_W(DW), .IMG_DIM(14), .K_NUM(9)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ifm_rd_en(ifm_rd_en), .ifm_addr(ifm_addr), .ifm_rdata(ifm_rdata),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
        .in_valid(in_valid), .In_IFM(In_IFM), .In_Weight(In_Weight),
        .busy(busy), .done(done), .frame_cnt(frame_cnt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Synchronous memories; a disabled port returns all ones.
    logic [DW-1:0] ifm_mem [0:255];
    logic [DW-1:0] w_mem   [0:15];

    always @(posedge clk) begin
        ifm_rdata <= (ifm_rd_en && ifm_addr < 8'd196) ? ifm_mem[ifm_addr] : 16'hFFFF;
        w_rdata   <= (w_rd_en && w_addr < 4'd9) ? w_mem[w_addr] : 16'hFFFF;
    end

    // Model: e = edges since reset release, k = edge of the accepted start of the
    // current/last frame. Everything else is a function of t = e - k.
    int e = 0;
    int k = -1;
    int frames = 0;
    int accepts = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e <= 0;
            k <= -1;
            frames <= 0;
            accepts <= 0;
        end else begin
            e <= e + 1;
            if (k >= 0 && e + 1 - k == 198) frames <= frames + 1;
            if (start && !(k >= 0 && e + 1 - k >= 1 && e + 1 - k <= 198)) begin
                k <= e + 1;
                accepts <= accepts + 1;
            end
        end
    end

    int t;
    logic act, exp_busy, exp_rd, exp_wrd, exp_valid, exp_done;
    logic [7:0] exp_addr, exp_cnt;
    logic [3:0] exp_waddr;
    logic [DW-1:0] exp_ifm, exp_w;

    assign t         = e - k;
    assign act       = (k >= 0);
    assign exp_busy  = act && t <= 197;
    assign exp_rd    = act && t <= 195;
    assign exp_addr  = exp_rd ? 8'(t) : 8'd0;
    assign exp_wrd   = act && t <= 8;
    assign exp_waddr = 4'(t);
    assign exp_valid = act && t >= 2 && t <= 197;
    assign exp_ifm   = exp_valid ? ifm_mem[8'(t - 2)] : '0;
    assign exp_w     = (exp_valid && t - 2 <= 8) ? w_mem[4'(t - 2)] : '0;
    assign exp_done  = act && t == 198;
    assign exp_cnt   = 8'(frames);

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, e, actual, expected);
        end
    endtask

    // Observation counters used by the hand-computed checks.
    int beats = 0, rises = 0, dones = 0, last_rise_e = -1, last_done_e = -1;
    int ifm_sum = 0, w_sum = 0;
    logic prev_valid = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("busy", busy, exp_busy);
                chk("ifm_rd_en", ifm_rd_en, exp_rd);
                chk("ifm_addr", ifm_addr, exp_addr);
                chk("w_rd_en", w_rd_en, exp_wrd);
                if (exp_wrd) chk("w_addr", w_addr, exp_waddr);
                chk("in_valid", in_valid, exp_valid);
                chk("In_IFM", In_IFM, exp_ifm);
                chk("In_Weight", In_Weight, exp_w);
                chk("done", done, exp_done);
                chk("frame_cnt", frame_cnt, exp_cnt);
                if (!exp_busy) chk("state_idle", dbg_state, 2'd0);
                if (in_valid) begin
                    beats++;
                    ifm_sum += int'(In_IFM);
                    w_sum += int'(In_Weight);
                    if (!prev_valid) begin
                        rises++;
                        last_rise_e = e;
                    end
                end
                if (done) begin
                    dones++;
                    last_done_e = e;
                end
                prev_valid = in_valid;
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    task automatic fill_mem(input bit pattern);
        for (int i = 0; i < 256; i++) ifm_mem[i] = pattern ? 16'(i + 1) : 16'($urandom);
        for (int i = 0; i < 16; i++) w_mem[i] = pattern ? 16'(16'h100 + i) : 16'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic pulse_at(input int n);
        while (e < n - 1) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_to(input int n);
        while (e < n) @(negedge clk);
        #1;
    endtask

    int b0, r0, d0, s0, ws0, lim;

    initial begin
        // Single frame with known contents.
        fill_mem(1'b1);
        do_reset();
        #1 chk("reset_busy", busy, 1'b0);
        chk("reset_in_valid", in_valid, 1'b0);
        chk("reset_frame_cnt", frame_cnt, 8'd0);
        b0 = beats; r0 = rises; s0 = ifm_sum; ws0 = w_sum;
        pulse_at(10);
        wait_to(260);
        chk("single_first_beat_edge", 32'(last_rise_e), 32'd12);
        chk("single_done_edge", 32'(last_done_e), 32'd208);
        chk("single_beats", 32'(beats - b0), 32'd196);
        chk("single_ifm_sum", 32'(ifm_sum - s0), 32'd19306);
        chk("single_w_sum", 32'(w_sum - ws0), 32'd2340);
        chk("single_frame_cnt", frame_cnt, 8'd1);

        // Start while busy is dropped, not queued.
        fill_mem(1'b0);
        do_reset();
        r0 = rises; d0 = dones;
        pulse_at(10);
        pulse_at(50);
        pulse_at(208);
        wait_to(450);
        chk("busy_start_bursts", 32'(rises - r0), 32'd1);
        chk("busy_start_dones", 32'(dones - d0), 32'd1);
        chk("busy_start_frame_cnt", frame_cnt, 8'd1);

        // Continuous start: accepts at edges 1, 200, 399.
        do_reset();
        r0 = rises;
        start = 1'b1;
        while (e < 590) @(negedge clk);
        start = 1'b0;
        wait_to(800);
        chk("cont_bursts", 32'(rises - r0), 32'd3);
        chk("cont_last_rise_edge", 32'(last_rise_e), 32'd401);
        chk("cont_last_done_edge", 32'(last_done_e), 32'd597);
        chk("cont_frame_cnt", frame_cnt, 8'd3);

        // Reset at beat 100 of a frame started at edge 5.
        fill_mem(1'b0);
        do_reset();
        d0 = dones;
        pulse_at(5);
        wait_to(107);
        chk("pre_reset_in_valid", in_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk("rst_in_valid", in_valid, 1'b0);
        chk("rst_In_IFM", In_IFM, 16'd0);
        chk("rst_In_Weight", In_Weight, 16'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ifm_rd_en", ifm_rd_en, 1'b0);
        chk("rst_ifm_addr", ifm_addr, 8'd0);
        chk("rst_frame_cnt", frame_cnt, 8'd0);
        chk("rst_no_done", 32'(dones - d0), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        b0 = beats;
        pulse_at(10);
        wait_to(230);
        chk("after_rst_beats", 32'(beats - b0), 32'd196);
        chk("after_rst_frame_cnt", frame_cnt, 8'd1);

        // Random start activity against the model.
        fill_mem(1'b0);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 15) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        wait_to(e + 250);
        chk("rand_frame_cnt", frame_cnt, 8'(accepts));

        // 256 back-to-back frames: frame_cnt wraps to 0.
        do_reset();
        d0 = dones;
        start = 1'b1;
        lim = 0;
        while (accepts < 256 && lim < 60000) begin
            @(negedge clk);
            lim++;
        end
        start = 1'b0;
        chk("wrap_accept_timeout", 32'(accepts), 32'd256);
        lim = 0;
        while (frames < 256 && lim < 400) begin
            @(negedge clk);
            lim++;
        end
        repeat (3) @(negedge clk);
        #1;
        chk("wrap_dones", 32'(dones - d0), 32'd256);
        chk("wrap_frame_cnt", frame_cnt, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
